mvu_job_sched: RTL and testbench

Job scheduler that sits between the host command path and the array of NMVU matrix-vector units. The host pushes job descriptors into a small in-order queue. The scheduler:
- waits until the target MVU is idle,
- loads that MVU's countdown and precision configuration registers,
- issues a one-cycle `start`,
- tracks per-MVU busy state until the MVU's `done` pulse, then raises a one-cycle `irq`.

---
 rtl/mvu_pkg.sv | 17 +
 rtl/mvu_job_fifo.sv | 46 ++++
 rtl/mvu_job_sched.sv | 147 ++++++++++++++
 tb/tb_mvu_job_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared types for the MVU job scheduler: the job descriptor and the dispatch FSM states.
package mvu_pkg;
    localparam int NMVU    = 8;
    localparam int BCNTDWN = 29;
    localparam int BPREC   = 6;
    localparam int BMVU    = $clog2(NMVU);

    typedef struct packed {
        logic [BMVU-1:0]    mvu;
        logic [BCNTDWN-1:0] countdown;
        logic [BPREC-1:0]   wprec;
        logic [BPREC-1:0]   iprec;
        logic [BPREC-1:0]   oprec;
    } mvu_job_t;

    typedef enum logic {IDLE = 1'b0, STRT = 1'b1} sched_state_t;
endpackage

// File: rtl/mvu_job_fifo.sv
// In-order descriptor queue; pointers carry one extra wrap bit so full and empty are distinguishable.
module mvu_job_fifo
    import mvu_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  mvu_job_t                 din,
    output mvu_job_t                 head,
    output logic [$clog2(QDEPTH):0]  count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(QDEPTH);

    mvu_job_t    r_mem [QDEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + 1'b1;
            if (pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wptr[AW-1:0]] <= din;
    end

    assign head  = r_mem[r_rptr[AW-1:0]];
    assign count = r_wptr - r_rptr;
    assign full  = (count == (AW+1)'(QDEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/mvu_job_sched.sv
// Dispatches queued jobs in order to idle MVUs, loads their config, pulses start,
// and tracks busy until done, raising a one-cycle irq per completion.
module mvu_job_sched #(
    parameter int NMVU    = mvu_pkg::NMVU,
    parameter int BCNTDWN = mvu_pkg::BCNTDWN,
    parameter int BPREC   = mvu_pkg::BPREC,
    parameter int QDEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [$clog2(NMVU)-1:0]   job_mvu,
    input  logic [BCNTDWN-1:0]        job_countdown,
    input  logic [BPREC-1:0]          job_wprec,
    input  logic [BPREC-1:0]          job_iprec,
    input  logic [BPREC-1:0]          job_oprec,
    input  logic [NMVU-1:0]           done,
    output logic [NMVU-1:0]           start,
    output logic [NMVU-1:0]           irq,
    output logic [NMVU-1:0]           busy,
    output logic [NMVU*BCNTDWN-1:0]   countdown,
    output logic [NMVU*BPREC-1:0]     wprecision,
    output logic [NMVU*BPREC-1:0]     iprecision,
    output logic [NMVU*BPREC-1:0]     oprecision,
    output logic [$clog2(QDEPTH):0]   qcount,
    output logic                      err_spurious,
    output logic                      err_badidx
);
    import mvu_pkg::mvu_job_t;
    import mvu_pkg::sched_state_t;

    localparam int BIDX = $clog2(NMVU);
    localparam int KMVU = mvu_pkg::BMVU;
    localparam int KCD  = mvu_pkg::BCNTDWN;
    localparam int KPR  = mvu_pkg::BPREC;

    sched_state_t                   r_state, w_state_nxt;
    mvu_job_t                       w_push_job, w_head;
    logic                           w_full, w_empty, w_push, w_pop, w_dispatch, w_badidx;
    logic [BIDX-1:0]                w_idx, r_strt_mvu;
    logic [NMVU-1:0]                r_busy, w_busy_nxt, r_start, r_irq;
    logic [NMVU-1:0][BCNTDWN-1:0]   r_cd;
    logic [NMVU-1:0][BPREC-1:0]     r_wp, r_ip, r_op;
    logic                           r_err_sp, r_err_bi;

    assign job_ready = !w_full;
    assign w_push    = job_valid && !w_full && !clr;

    always_comb begin
        w_push_job           = '0;
        w_push_job.mvu       = KMVU'(job_mvu);
        w_push_job.countdown = KCD'(job_countdown);
        w_push_job.wprec     = KPR'(job_wprec);
        w_push_job.iprec     = KPR'(job_iprec);
        w_push_job.oprec     = KPR'(job_oprec);
    end

    mvu_job_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clr),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_job),
        .head  (w_head),
        .count (qcount),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_idx = BIDX'(w_head.mvu);

    // Dispatch looks at the registered busy bit, so a done in the same cycle delays it by one.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_dispatch  = 1'b0;
        w_badidx    = 1'b0;
        if (r_state == mvu_pkg::STRT) begin
            w_state_nxt = mvu_pkg::IDLE;
        end else if (!w_empty) begin
            if (int'(w_idx) >= NMVU) begin
                w_pop    = 1'b1;
                w_badidx = 1'b1;
            end else if (!r_busy[w_idx]) begin
                w_pop       = 1'b1;
                w_dispatch  = 1'b1;
                w_state_nxt = mvu_pkg::STRT;
            end
        end
        if (clr) begin
            w_state_nxt = mvu_pkg::IDLE;
            w_pop       = 1'b0;
            w_dispatch  = 1'b0;
            w_badidx    = 1'b0;
        end
    end

    always_comb begin
        w_busy_nxt = r_busy & ~done;
        if (w_dispatch) w_busy_nxt[w_idx] = 1'b1;
        if (clr && r_state == mvu_pkg::STRT) w_busy_nxt[r_strt_mvu] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= mvu_pkg::IDLE;
            r_strt_mvu <= '0;
            r_busy     <= '0;
            r_start    <= '0;
            r_irq      <= '0;
            r_cd       <= '0;
            r_wp       <= '0;
            r_ip       <= '0;
            r_op       <= '0;
            r_err_sp   <= 1'b0;
            r_err_bi   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_irq   <= done & r_busy;
            r_start <= '0;
            if (r_state == mvu_pkg::STRT && !clr) r_start[r_strt_mvu] <= 1'b1;
            if (|(done & ~r_busy)) r_err_sp <= 1'b1;
            if (w_badidx) r_err_bi <= 1'b1;
            if (w_dispatch) begin
                r_strt_mvu  <= w_idx;
                r_cd[w_idx] <= BCNTDWN'(w_head.countdown);
                r_wp[w_idx] <= BPREC'(w_head.wprec);
                r_ip[w_idx] <= BPREC'(w_head.iprec);
                r_op[w_idx] <= BPREC'(w_head.oprec);
            end
        end
    end

    assign start        = r_start;
    assign irq          = r_irq;
    assign busy         = r_busy;
    assign countdown    = r_cd;
    assign wprecision   = r_wp;
    assign iprecision   = r_ip;
    assign oprecision   = r_op;
    assign err_spurious = r_err_sp;
    assign err_badidx   = r_err_bi;
endmodule

// File: tb/tb_mvu_job_sched.sv
// Directed bench for mvu_job_sched with NMVU=6 so an out-of-range index is encodable.
module tb_mvu_job_sched;
    localparam int NMVU = 6;
    localparam int BCD  = 29;
    localparam int BPR  = 6;
    localparam int QD   = 4;

    logic                 clk, rst_n, clr, job_valid, job_ready;
    logic [2:0]           job_mvu;
    logic [BCD-1:0]       job_countdown;
    logic [BPR-1:0]       job_wprec, job_iprec, job_oprec;
    logic [NMVU-1:0]      done, start, irq, busy;
    logic [NMVU*BCD-1:0]  countdown;
    logic [NMVU*BPR-1:0]  wprecision, iprecision, oprecision;
    logic [2:0]           qcount;
    logic                 err_spurious, err_badidx;

    int checks   = 0;
    int failures = 0;

    mvu_job_sched #(.NMVU(NMVU), .BCNTDWN(BCD), .BPREC(BPR), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .job_valid(job_valid), .job_ready(job_ready),
        .job_mvu(job_mvu), .job_countdown(job_countdown), .job_wprec(job_wprec),
        .job_iprec(job_iprec), .job_oprec(job_oprec), .done(done), .start(start),
        .irq(irq), .busy(busy), .countdown(countdown), .wprecision(wprecision),
        .iprecision(iprecision), .oprecision(oprecision), .qcount(qcount),
        .err_spurious(err_spurious), .err_badidx(err_badidx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] m, input int cd, input logic [5:0] p);
        job_valid     = 1'b1;
        job_mvu       = m;
        job_countdown = BCD'(cd);
        job_wprec     = p;
        job_iprec     = p;
        job_oprec     = p;
        tick;
        job_valid     = 1'b0;
    endtask

    function automatic logic [BCD-1:0] cdv(input int m);
        return countdown[m*BCD +: BCD];
    endfunction

    initial begin
        rst_n = 1'b0; clr = 1'b0; job_valid = 1'b0; job_mvu = '0; job_countdown = '0;
        job_wprec = '0; job_iprec = '0; job_oprec = '0; done = '0;
        #3;
        chk("rst_qcount", qcount, 0);
        chk("rst_ready", job_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start_irq", {start, irq}, 0);
        chk("rst_cfg", |{countdown, wprecision, iprecision, oprecision}, 0);
        chk("rst_err", {err_spurious, err_badidx}, 0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        tick;

        // Single job to MVU 2
        push(3'd2, 100, 6'd2);
        chk("t1_q_after_push", qcount, 1);
        chk("t1_busy_e0", busy, 0);
        tick;
        chk("t1_busy_e1", busy, 6'b000100);
        chk("t1_cd_e1", cdv(2), 100);
        chk("t1_wp_e1", wprecision[2*BPR +: BPR], 2);
        chk("t1_q_e1", qcount, 0);
        chk("t1_start_e1", start, 0);
        tick;
        chk("t1_start_e2", start, 6'b000100);
        tick;
        chk("t1_start_e3", start, 0);
        done = 6'b000100;
        tick;
        done = '0;
        chk("t1_irq", irq, 6'b000100);
        chk("t1_busy_done", busy, 0);
        tick;
        chk("t1_irq_fall", irq, 0);
        chk("t1_no_spur", err_spurious, 0);

        // Five jobs to MVU 1: one dispatches, four fill the queue
        for (int k = 0; k < 5; k++) push(3'd1, 10*(k+1), 6'd1);
        chk("t2_q_full", qcount, 4);
        chk("t2_ready_low", job_ready, 0);
        push(3'd1, 99, 6'd1);
        chk("t2_q_reject", qcount, 4);
        chk("t2_cd0", cdv(1), 10);
        for (int k = 1; k < 5; k++) begin
            tick;
            chk("t2_wait_start", start, 0);
            chk("t2_wait_busy", busy, 6'b000010);
            done = 6'b000010;
            tick;
            done = '0;
            chk("t2_irq", irq, 6'b000010);
            chk("t2_busy_clr", busy, 0);
            tick;
            chk("t2_redisp_busy", busy, 6'b000010);
            chk("t2_cd_order", cdv(1), BCD'(10*(k+1)));
            chk("t2_q_dec", qcount, 3'(4-k));
            tick;
            chk("t2_start", start, 6'b000010);
            tick;
            chk("t2_start_fall", start, 0);
        end
        done = 6'b000010;
        tick;
        done = '0;
        tick;
        chk("t2_idle", busy, 0);

        // Head-of-line blocking: second MVU0 job stalls the MVU3 job behind it
        push(3'd0, 7, 6'd3);
        push(3'd0, 8, 6'd3);
        push(3'd3, 33, 6'd3);
        chk("t3_start0", start, 6'b000001);
        chk("t3_q", qcount, 2);
        tick;
        tick;
        chk("t3_blocked_busy", busy, 6'b000001);
        chk("t3_blocked_q", qcount, 2);
        done = 6'b000001;
        tick;
        done = '0;
        chk("t3_irq0", irq, 6'b000001);
        tick;
        chk("t3_redisp0", busy, 6'b000001);
        chk("t3_cd0", cdv(0), 8);
        chk("t3_q1", qcount, 1);
        tick;
        chk("t3_start0b", start, 6'b000001);
        tick;
        chk("t3_disp3", busy, 6'b001001);
        chk("t3_cd3", cdv(3), 33);
        chk("t3_q0", qcount, 0);
        tick;
        chk("t3_start3", start, 6'b001000);
        tick;
        chk("t3_start3_fall", start, 0);
        done = 6'b001001;
        tick;
        done = '0;
        chk("t3_irq_both", irq, 6'b001001);
        chk("t3_busy_none", busy, 0);

        // Spurious done and bad index
        done = 6'b100000;
        tick;
        done = '0;
        chk("t4_spur", err_spurious, 1);
        chk("t4_spur_irq", irq, 0);
        push(3'd7, 5, 6'd1);
        tick;
        chk("t4_badidx", err_badidx, 1);
        chk("t4_bad_q", qcount, 0);
        chk("t4_bad_busy", busy, 0);
        tick;
        chk("t4_bad_nostart", start, 0);

        // Flush while in STRT for MVU 4 with two jobs queued
        push(3'd2, 1, 6'd1);
        push(3'd4, 44, 6'd4);
        push(3'd4, 45, 6'd4);
        push(3'd4, 46, 6'd4);
        chk("t5_pre_busy", busy, 6'b010100);
        chk("t5_pre_q", qcount, 2);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("t5_nostart", start, 0);
        chk("t5_busy", busy, 6'b000100);
        chk("t5_q", qcount, 0);
        chk("t5_ready", job_ready, 1);
        chk("t5_cfg_kept", cdv(4), 44);
        chk("t5_err_kept", {err_spurious, err_badidx}, 2'b11);
        tick;
        chk("t5_nostart2", start, 0);
        chk("t5_busy2", busy, 6'b000100);

        // Async reset mid-job
        push(3'd0, 1, 6'd1);
        push(3'd1, 2, 6'd1);
        push(3'd3, 3, 6'd1);
        push(3'd0, 4, 6'd1);
        push(3'd0, 5, 6'd1);
        push(3'd0, 6, 6'd1);
        chk("t6_pre_busy", busy, 6'b001111);
        chk("t6_pre_q", qcount, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_q", qcount, 0);
        chk("t6_rst_ready", job_ready, 1);
        chk("t6_rst_outs", {start, irq, err_spurious, err_badidx}, 0);
        chk("t6_rst_cfg", |{countdown, wprecision, iprecision, oprecision}, 0);
        #3;
        rst_n = 1'b1;
        tick;
        done = 6'b000100;
        tick;
        done = '0;
        chk("t6_late_spur", err_spurious, 1);
        chk("t6_late_irq", irq, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
